// File: rtl/mem_dual_issue_seq.sv
// Dual-slot memory op sequencer: issues slot1 then slot2 on one dcache port,
// checks alignment, lane-shifts stores, extracts/extends loads, and returns
// both results in a single completion beat.
module mem_dual_issue_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op1_vld,
  input  logic              op1_we,
  input  logic [ADDR_W-1:0] op1_addr,
  input  logic [3:0]        op1_width,
  input  logic              op1_unsigned,
  input  logic [DATA_W-1:0] op1_wdata,
  input  logic              op2_vld,
  input  logic              op2_we,
  input  logic [ADDR_W-1:0] op2_addr,
  input  logic [3:0]        op2_width,
  input  logic              op2_unsigned,
  input  logic [DATA_W-1:0] op2_wdata,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_req_we,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [3:0]        dc_req_strb,
  output logic [DATA_W-1:0] dc_req_wdata,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res1_data,
  output logic              res1_ale,
  output logic [DATA_W-1:0] res2_data,
  output logic              res2_ale
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_DONE, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // Captured issue group, index 0 = slot1, index 1 = slot2
  logic [1:0]             vld_q, we_q, uns_q, ale_q;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0][3:0]        wid_q;
  logic [1:0][DATA_W-1:0] wdata_q, res_q;

  // Unknown width encodings collapse to word
  function automatic logic [3:0] norm_w(input logic [3:0] w);
    case (w)
      4'b0001: norm_w = 4'b0001;
      4'b0011: norm_w = 4'b0011;
      default: norm_w = 4'b1111;
    endcase
  endfunction

  function automatic logic is_ale(input logic [3:0] w, input logic [1:0] lo);
    is_ale = ((w == 4'b0011) & lo[0]) | ((w == 4'b1111) & (|lo));
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rd,
                                                 input logic [1:0] lane,
                                                 input logic [3:0] w,
                                                 input logic uns);
    logic [DATA_W-1:0] sh;
    sh = rd >> {lane, 3'b000};
    case (w)
      4'b0001: load_ext = {{(DATA_W-8){~uns & sh[7]}}, sh[7:0]};
      4'b0011: load_ext = {{(DATA_W-16){~uns & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  logic [3:0] w1_n, w2_n;
  logic       ale1, ale2, accept, sel, rsel, resp_take;

  assign w1_n      = norm_w(op1_width);
  assign w2_n      = norm_w(op2_width);
  assign ale1      = op1_vld & is_ale(w1_n, op1_addr[1:0]);
  // A misaligned slot1 kills slot2 entirely, including its own ALE report
  assign ale2      = op2_vld & is_ale(w2_n, op2_addr[1:0]) & ~ale1;
  assign accept    = in_valid & in_ready;
  assign sel       = (state_q == S_REQ2);
  assign rsel      = (state_q == S_WAIT2);
  assign resp_take = dc_resp_valid & ((state_q == S_WAIT1) | (state_q == S_WAIT2));

  assign dc_req_we    = we_q[sel];
  assign dc_req_addr  = {addr_q[sel][ADDR_W-1:2], 2'b00};
  assign dc_req_strb  = wid_q[sel] << addr_q[sel][1:0];
  assign dc_req_wdata = wdata_q[sel] << {addr_q[sel][1:0], 3'b000};

  assign res1_data = res_q[0];
  assign res2_data = res_q[1];
  assign res1_ale  = ale_q[0];
  assign res2_ale  = ale_q[1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; flush outranks every other transition
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    dc_req_valid = 1'b0;
    out_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = ~flush;
        if (in_valid && !flush) begin
          if (op1_vld && !ale1)                    state_d = S_REQ1;
          else if (!op1_vld && op2_vld && !ale2)   state_d = S_REQ2;
          else                                     state_d = S_DONE;
        end
      end
      S_REQ1, S_REQ2: begin
        dc_req_valid = 1'b1;
        if (flush)             state_d = dc_req_ready ? S_DRAIN : S_IDLE;
        else if (dc_req_ready) state_d = sel ? S_WAIT2 : S_WAIT1;
      end
      S_WAIT1, S_WAIT2: begin
        // A response landing in the flush cycle retires the outstanding
        // request, so there is nothing left to drain.
        if (flush)              state_d = dc_resp_valid ? S_IDLE : S_DRAIN;
        else if (dc_resp_valid) state_d = (!rsel && vld_q[1] && !ale_q[1]) ? S_REQ2 : S_DONE;
      end
      S_DONE: begin
        out_valid = ~flush;
        if (flush || out_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dc_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Group capture and per-slot result collection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      we_q    <= '0;
      uns_q   <= '0;
      ale_q   <= '0;
      addr_q  <= '0;
      wid_q   <= '0;
      wdata_q <= '0;
      res_q   <= '0;
    end else if (accept) begin
      vld_q      <= {op2_vld, op1_vld};
      we_q       <= {op2_we, op1_we};
      uns_q      <= {op2_unsigned, op1_unsigned};
      ale_q      <= {ale2, ale1};
      addr_q[0]  <= op1_addr;
      addr_q[1]  <= op2_addr;
      wid_q[0]   <= w1_n;
      wid_q[1]   <= w2_n;
      wdata_q[0] <= op1_wdata;
      wdata_q[1] <= op2_wdata;
      res_q      <= '0;
    end else if (flush) begin
      res_q <= '0;
      ale_q <= '0;
    end else if (resp_take) begin
      res_q[rsel] <= we_q[rsel] ? '0
                   : load_ext(dc_resp_rdata, addr_q[rsel][1:0], wid_q[rsel], uns_q[rsel]);
    end
  end

endmodule

// File: tb/tb_mem_dual_issue_seq.sv
// Scoreboarded bench for mem_dual_issue_seq: random groups against a byte-level
// memory reference model, then directed latency/stall/flush/reset scenarios.
module tb_mem_dual_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op1_vld = 0, op1_we = 0, op1_unsigned = 0;
  logic [31:0] op1_addr = 0, op1_wdata = 0;
  logic [3:0]  op1_width = 0;
  logic        op2_vld = 0, op2_we = 0, op2_unsigned = 0;
  logic [31:0] op2_addr = 0, op2_wdata = 0;
  logic [3:0]  op2_width = 0;
  logic        dc_req_valid, dc_req_we;
  logic        dc_req_ready = 1'b1;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_strb;
  logic        dc_resp_valid = 1'b0;
  logic [31:0] dc_resp_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res1_data, res2_data;
  logic        res1_ale, res2_ale;

  mem_dual_issue_seq dut (
    .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op1_vld(op1_vld), .op1_we(op1_we), .op1_addr(op1_addr), .op1_width(op1_width),
    .op1_unsigned(op1_unsigned), .op1_wdata(op1_wdata),
    .op2_vld(op2_vld), .op2_we(op2_we), .op2_addr(op2_addr), .op2_width(op2_width),
    .op2_unsigned(op2_unsigned), .op2_wdata(op2_wdata),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_strb(dc_req_strb), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .res1_data(res1_data), .res1_ale(res1_ale), .res2_data(res2_data), .res2_ale(res2_ale)
  );

  always #5 clk = ~clk;

  typedef struct { bit vld; bit we; bit uns; logic [31:0] addr; logic [31:0] wdata; logic [3:0] w; } op_t;
  typedef struct { logic [31:0] r1; logic [31:0] r2; bit a1; bit a2; } grp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } req_t;

  grp_t        exp_q[$];
  req_t        req_q[$];
  logic [31:0] ref_force[$], dut_force[$];
  logic [31:0] ref_mem[int];
  logic [31:0] dut_mem[int];

  int total = 0, bad = 0;
  int cyc = 0;
  int hs_count = 0, last_hold = 0, stall = 0, fixed_dly = -1, ov_cyc = -1;
  bit rdy_rand = 1'b1, or_rand = 1'b1, pend = 1'b0;
  req_t last_req;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int k);
    logic [31:0] kk;
    kk = k;
    return (kk * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int nbytes(input logic [3:0] w);
    if (w == 4'b0001) return 1;
    if (w == 4'b0011) return 2;
    return 4;
  endfunction

  function automatic bit misal(input op_t o);
    int n;
    logic [31:0] a;
    n = nbytes(o.w);
    a = o.addr;
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
  endfunction

  // Reference: one memory op against a byte-addressed view of memory
  task automatic ref_run(input op_t o, output logic [31:0] res);
    int n, lane, k, s;
    logic [31:0] word, t, mask, a;
    req_t r;
    a    = o.addr;
    n    = nbytes(o.w);
    lane = int'(a[1:0]);
    k    = int'(a >> 2);
    s    = ((1 << n) - 1) << lane;
    r.we    = o.we;
    r.addr  = a & 32'hFFFF_FFFC;
    r.strb  = s[3:0];
    r.wdata = o.wdata << (8 * lane);
    req_q.push_back(r);
    if (!ref_mem.exists(k)) ref_mem[k] = init_word(k);
    res = 32'h0;
    if (o.we) begin
      t = ref_mem[k];
      for (int i = 0; i < n; i++) t[8*(lane+i) +: 8] = o.wdata[8*i +: 8];
      ref_mem[k] = t;
    end else begin
      word = (ref_force.size() != 0) ? ref_force.pop_front() : ref_mem[k];
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      res  = (word >> (8 * lane)) & mask;
      if (!o.uns && n < 4 && res[8*n-1]) res = res | ~mask;
    end
  endtask

  task automatic ref_group(input op_t o1, input op_t o2);
    grp_t g;
    g.a1 = o1.vld && misal(o1);
    g.a2 = o2.vld && misal(o2) && !g.a1;
    g.r1 = 32'h0;
    g.r2 = 32'h0;
    if (o1.vld && !g.a1) ref_run(o1, g.r1);
    if (o2.vld && !g.a2 && !g.a1) ref_run(o2, g.r2);
    exp_q.push_back(g);
  endtask

  task automatic issue(input op_t o1, input op_t o2, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    op1_vld = o1.vld; op1_we = o1.we; op1_addr = o1.addr; op1_width = o1.w;
    op1_unsigned = o1.uns; op1_wdata = o1.wdata;
    op2_vld = o2.vld; op2_we = o2.we; op2_addr = o2.addr; op2_width = o2.w;
    op2_unsigned = o2.uns; op2_wdata = o2.wdata;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; acc_cyc = cyc; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL issue_timeout: in_ready never rose");
    end else begin
      ref_group(o1, o2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready && !pend) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: pending=%0d in_ready=%0d", nm, exp_q.size(), in_ready);
    end
    @(posedge clk); #1;
  endtask

  function automatic op_t mk(input bit v, input bit we, input logic [31:0] a,
                             input logic [3:0] w, input bit u, input logic [31:0] d);
    op_t o;
    o.vld = v; o.we = we; o.addr = a; o.w = w; o.uns = u; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int r;
    o.vld   = ($urandom_range(0, 3) != 0);
    o.we    = 1'($urandom_range(0, 1));
    o.uns   = 1'($urandom_range(0, 1));
    o.addr  = 32'h1000 + 32'($urandom_range(0, 31));
    o.wdata = $urandom;
    r = $urandom_range(0, 7);
    if (r < 3)      o.w = 4'b0001;
    else if (r < 5) o.w = 4'b0011;
    else if (r < 7) o.w = 4'b1111;
    else            o.w = 4'($urandom_range(0, 15));
    return o;
  endfunction

  // Dcache model: checks each accepted request, answers it after a delay
  initial begin : responder
    bit hs, pw, vseen;
    int hold, dly, k;
    req_t seen, prev, r;
    logic [31:0] pend_data, t;
    hs = 0; pw = 0; vseen = 0; hold = 0; dly = 0; pend_data = 0;
    forever begin
      @(negedge clk);
      vseen = dc_req_valid;
      hs = rst_n && dc_req_valid && dc_req_ready;
      if (rst_n && dc_req_valid) begin
        if (pw) begin
          chk("req_stable_addr", dc_req_addr, prev.addr);
          chk("req_stable_wdata", dc_req_wdata, prev.wdata);
          chk("req_stable_ctl", {27'b0, dc_req_we, dc_req_strb}, {27'b0, prev.we, prev.strb});
        end
        prev.addr = dc_req_addr; prev.wdata = dc_req_wdata;
        prev.we = dc_req_we; prev.strb = dc_req_strb;
        hold++;
      end
      pw = rst_n && dc_req_valid && !dc_req_ready;
      if (hs) begin
        last_hold = hold; hold = 0;
        seen.addr = dc_req_addr; seen.wdata = dc_req_wdata;
        seen.we = dc_req_we; seen.strb = dc_req_strb;
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        pend = 0; dc_resp_valid = 0; hold = 0; pw = 0;
      end else begin
        dc_resp_valid = 1'b0;
        if (hs) begin
          hs_count++;
          last_req = seen;
          if (req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: addr %h strb %h", seen.addr, seen.strb);
          end else begin
            r = req_q.pop_front();
            chk("req_addr", seen.addr, r.addr);
            chk("req_strb_we", {27'b0, seen.we, seen.strb}, {27'b0, r.we, r.strb});
            if (r.we) chk("req_wdata", seen.wdata, r.wdata);
          end
          k = int'(seen.addr >> 2);
          if (!dut_mem.exists(k)) dut_mem[k] = init_word(k);
          if (seen.we) begin
            t = dut_mem[k];
            for (int i = 0; i < 4; i++) if (seen.strb[i]) t[8*i +: 8] = seen.wdata[8*i +: 8];
            dut_mem[k] = t;
            pend_data = $urandom;
          end else begin
            pend_data = (dut_force.size() != 0) ? dut_force.pop_front() : dut_mem[k];
          end
          pend = 1'b1;
          dly = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 2);
        end
        if (pend) begin
          if (dly == 0) begin
            dc_resp_valid = 1'b1; dc_resp_rdata = pend_data; pend = 1'b0;
          end else dly--;
        end
      end
      if (stall > 0 && vseen) stall--;
      dc_req_ready = (stall > 0) ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      out_ready    = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Completion monitor: pops the oldest expected group on every out handshake
  initial begin : monitor
    bit ov_prev;
    grp_t g;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !ov_prev) ov_cyc = cyc;
      ov_prev = out_valid;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: res1 %h res2 %h", res1_data, res2_data);
        end else begin
          g = exp_q.pop_front();
          chk("res1_data", res1_data, g.r1);
          chk("res2_data", res2_data, g.r2);
          chk("res_ale", {30'b0, res2_ale, res1_ale}, {30'b0, g.a2, g.a1});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    int acc, base;
    bit ok;
    op_t none;
    none = mk(0, 0, 32'h0, 4'b1111, 0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {29'b0, in_ready, dc_req_valid, out_valid}, 32'b100);
    chk("reset_res", res1_data | res2_data | {30'b0, res1_ale, res2_ale}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random groups with random backpressure and response delay
    for (int g = 0; g < 200; g++) begin
      issue(rnd_op(), rnd_op(), acc);
    end
    wait_idle("random");

    rdy_rand = 1'b0; or_rand = 1'b0; fixed_dly = 0;
    @(posedge clk); #1;

    // T1: lw + lb unsigned, full-rate latency
    ref_force.push_back(32'h8899AABB); ref_force.push_back(32'h11223344);
    dut_force.push_back(32'h8899AABB); dut_force.push_back(32'h11223344);
    ov_cyc = -1;
    issue(mk(1, 0, 32'h100, 4'b1111, 0, 0), mk(1, 0, 32'h103, 4'b0001, 1, 0), acc);
    wait_idle("t1");
    chk("t1_latency", 32'(ov_cyc - acc), 32'd5);

    // T2: half store in slot2 only
    ov_cyc = -1;
    issue(none, mk(1, 1, 32'h202, 4'b0011, 0, 32'h0000BEEF), acc);
    wait_idle("t2");
    chk("t2_addr", last_req.addr, 32'h200);
    chk("t2_strb_we", {27'b0, last_req.we, last_req.strb}, {27'b0, 1'b1, 4'b1100});
    chk("t2_wdata", last_req.wdata, 32'hBEEF0000);
    chk("t2_latency", 32'(ov_cyc - acc), 32'd3);

    // T3: slot1 misaligned word suppresses slot2, no dcache traffic
    base = hs_count; ov_cyc = -1;
    issue(mk(1, 0, 32'h101, 4'b1111, 0, 0), mk(1, 0, 32'h300, 4'b1111, 0, 0), acc);
    wait_idle("t3");
    chk("t3_no_req", 32'(hs_count - base), 32'd0);
    chk("t3_latency", 32'(ov_cyc - acc), 32'd1);

    // T4: signed half load with request stalled 3 cycles
    ref_force.push_back(32'h80010000); dut_force.push_back(32'h80010000);
    stall = 3;
    issue(mk(1, 0, 32'h006, 4'b0011, 0, 0), none, acc);
    wait_idle("t4");
    chk("t4_hold_cycles", 32'(last_hold), 32'd4);

    // T5: flush while waiting on the first response
    fixed_dly = 3; base = hs_count;
    issue(mk(1, 0, 32'h400, 4'b1111, 0, 0), mk(1, 0, 32'h404, 4'b1111, 0, 0), acc);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #2;
      if (hs_count == base + 1) begin ok = 1'b1; break; end
    end
    chk("t5_req1_seen", {31'b0, ok}, 32'd1);
    flush = 1'b1;
    void'(exp_q.pop_back());
    void'(req_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t5_drain", {29'b0, in_ready, dc_req_valid, out_valid}, 32'b000);
    end
    @(negedge clk);
    chk("t5_idle_after_resp", {29'b0, in_ready, dc_req_valid, out_valid}, 32'b100);
    chk("t5_one_req", 32'(hs_count - base), 32'd1);
    @(posedge clk); #1;

    // T6: async reset while waiting on the second response
    base = hs_count;
    issue(mk(1, 0, 32'h500, 4'b1111, 0, 0), mk(1, 0, 32'h504, 4'b0011, 0, 0), acc);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #2;
      if (hs_count == base + 2) begin ok = 1'b1; break; end
    end
    chk("t6_req2_seen", {31'b0, ok}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete(); req_q.delete();
    #1;
    chk("t6_reset_ctl", {29'b0, in_ready, dc_req_valid, out_valid}, 32'b100);
    chk("t6_reset_res", res1_data | res2_data | {30'b0, res1_ale, res2_ale}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle", {29'b0, in_ready, dc_req_valid, out_valid}, 32'b100);
    @(posedge clk); #1;

    // Post-reset group proves the block is usable again
    fixed_dly = 1;
    issue(mk(1, 1, 32'h600, 4'b1111, 0, 32'hCAFEF00D), mk(1, 0, 32'h600, 4'b0001, 0, 0), acc);
    wait_idle("post_reset");

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_req_empty", 32'(req_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
